// File: rtl/jkff_cmd_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one bank of WIDTH external
// JK flip-flops: it drives j/k for one cycle, then checks the q readback.
module jkff_cmd_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        op,
  input  logic [WIDTH*NREQ-1:0]    mask,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic                     busy,
  output logic [WIDTH-1:0]         j,
  output logic [WIDTH-1:0]         k,
  input  logic [WIDTH-1:0]         q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  j_q, j_d;
  logic [WIDTH-1:0]  k_q, k_d;

  logic              found;
  logic [IW-1:0]     win;
  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  sel_mask;
  int                cand;

  // Value the bank should hold after one JK edge with the given op on masked bits.
  function automatic logic [WIDTH-1:0] expect_val(input logic [1:0]       o,
                                                  input logic [WIDTH-1:0] m,
                                                  input logic [WIDTH-1:0] qv);
    case (o)
      2'b01:   expect_val = qv & ~m;
      2'b10:   expect_val = qv | m;
      2'b11:   expect_val = qv ^ m;
      default: expect_val = qv;
    endcase
  endfunction

  // First active request at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = (int'(rr_q) + off) % NREQ;
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
    sel_op   = op[2*win +: 2];
    sel_mask = mask[WIDTH*win +: WIDTH];
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    op_d    = op_q;
    mask_d  = mask_q;
    exp_d   = exp_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    j_d     = '0;
    k_d     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d      = win;
          op_d       = sel_op;
          mask_d     = sel_mask;
          exp_d      = expect_val(sel_op, sel_mask, q);
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          j_d        = sel_mask & {WIDTH{sel_op[1]}};
          k_d        = sel_mask & {WIDTH{sel_op[0]}};
          state_d    = APPLY;
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        done_d[idx_q] = 1'b1;
        err_d         = (q != exp_q);
        gnt_d         = '0;
        rr_d          = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d       = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      op_q    <= '0;
      mask_q  <= '0;
      exp_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      exp_q   <= exp_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign j    = j_q;
  assign k    = k_q;

endmodule

// File: tb/tb_jkff_cmd_arbiter.sv
// Directed bench for jkff_cmd_arbiter with a behavioural JK bank model on j/k/q.
module tb_jkff_cmd_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [2*NREQ-1:0]     op = '0;
  logic [WIDTH*NREQ-1:0] mask = '0;
  logic [NREQ-1:0]       gnt, done;
  logic                  err, busy;
  logic [WIDTH-1:0]      j, k, q;
  logic [WIDTH-1:0]      bank = 8'hA5;
  logic [WIDTH-1:0]      stuck = '0;

  int tests = 0;
  int fails = 0;

  jkff_cmd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .mask(mask),
    .gnt(gnt), .done(done), .err(err), .busy(busy),
    .j(j), .k(k), .q(q)
  );

  always #5 clk = ~clk;

  // External JK bank, never reset by the DUT; stuck bits read back as 0.
  always @(posedge clk) begin
    for (int b = 0; b < WIDTH; b++) begin
      case ({j[b], k[b]})
        2'b10:   bank[b] <= 1'b1;
        2'b01:   bank[b] <= 1'b0;
        2'b11:   bank[b] <= ~bank[b];
        default: bank[b] <= bank[b];
      endcase
    end
  end
  assign q = bank & ~stuck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One isolated operation from IDLE; leaves the bench at the negedge after E3.
  task automatic run_op(input string tag, input int idx, input logic [1:0] o,
                        input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] ej,
                        input logic [WIDTH-1:0] ek, input logic [WIDTH-1:0] eq,
                        input logic eerr);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    @(negedge clk);
    req[idx] = 1'b1;
    op[2*idx +: 2] = o;
    mask[WIDTH*idx +: WIDTH] = m;
    @(negedge clk);
    check({tag, " apply gnt"}, 32'(gnt), 32'(oh));
    check({tag, " apply j"}, 32'(j), 32'(ej));
    check({tag, " apply k"}, 32'(k), 32'(ek));
    check({tag, " apply busy"}, 32'(busy), 32'd1);
    check({tag, " apply done"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, " check gnt"}, 32'(gnt), 32'(oh));
    check({tag, " check jk"}, 32'({j, k}), 32'd0);
    check({tag, " check q"}, 32'(q), 32'(eq));
    check({tag, " check done"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, " done gnt"}, 32'(gnt), 32'd0);
    check({tag, " done pulse"}, 32'(done), 32'(oh));
    check({tag, " done err"}, 32'(err), 32'(eerr));
    check({tag, " done busy"}, 32'(busy), 32'd1);
    req[idx] = 1'b0;
    @(negedge clk);
    check({tag, " idle done"}, 32'(done), 32'd0);
    check({tag, " idle err"}, 32'(err), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    int               idx;
    logic [1:0]       o;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] ej;
    logic [WIDTH-1:0] ek;
    logic [WIDTH-1:0] eq;
    logic             eerr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [NREQ-1:0] order[4];
    logic [NREQ-1:0] prev_gnt;
    int gcount, dcount, last_g;

    vecs[0] = '{0, 2'b01, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[1] = '{1, 2'b10, 8'h0F, 8'h0F, 8'h00, 8'h0F, 1'b0};
    vecs[2] = '{2, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'hF0, 1'b0};
    vecs[3] = '{3, 2'b00, 8'hFF, 8'h00, 8'h00, 8'hF0, 1'b0};
    vecs[4] = '{0, 2'b11, 8'h00, 8'h00, 8'h00, 8'hF0, 1'b0};
    vecs[5] = '{1, 2'b01, 8'hF0, 8'h00, 8'hF0, 8'h00, 1'b0};
    vecs[6] = '{2, 2'b10, 8'h3C, 8'h3C, 8'h00, 8'h3C, 1'b0};

    repeat (2) @(negedge clk);
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset jk", 32'({j, k}), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++)
      run_op($sformatf("v%0d", v), vecs[v].idx, vecs[v].o, vecs[v].m,
             vecs[v].ej, vecs[v].ek, vecs[v].eq, vecs[v].eerr);

    // Last grant went to 2: all four asking must be served 3,0,1,2, 4 cycles apart.
    order[0] = 4'b1000; order[1] = 4'b0001; order[2] = 4'b0010; order[3] = 4'b0100;
    op   = {2'b11, 2'b00, 2'b01, 2'b10};
    mask = {8'h01, 8'hFF, 8'h0F, 8'h80};
    req  = 4'b1111;
    prev_gnt = '0;
    gcount = 0; dcount = 0; last_g = 0;
    for (int cyc = 0; cyc < 40 && dcount < 4; cyc++) begin
      @(negedge clk);
      if (gnt != 0 && prev_gnt == 0) begin
        if (gcount < 4) check($sformatf("rr grant %0d", gcount), 32'(gnt), 32'(order[gcount]));
        if (gcount > 0) check($sformatf("rr spacing %0d", gcount), 32'(cyc - last_g), 32'd4);
        last_g = cyc;
        gcount++;
      end
      if (done != 0) begin
        if (dcount < 4) check($sformatf("rr done %0d", dcount), 32'(done), 32'(order[dcount]));
        check($sformatf("rr err %0d", dcount), 32'(err), 32'd0);
        req = req & ~done;
        dcount++;
      end
      prev_gnt = gnt;
    end
    check("rr grant count", 32'(gcount), 32'd4);
    check("rr done count", 32'(dcount), 32'd4);
    check("rr final q", 32'(q), 32'hB0);
    req = '0;

    // Bit 0 stuck low: set cannot be confirmed, err rides with done.
    stuck = 8'h01;
    run_op("stuck", 0, 2'b10, 8'h01, 8'h01, 8'h00, 8'hB0, 1'b1);
    stuck = 8'h00;

    // Reset during APPLY aborts silently; pointer returns to 0.
    @(negedge clk);
    req[1] = 1'b1; op[3:2] = 2'b10; mask[15:8] = 8'hFF;
    @(negedge clk);
    check("abort gnt", 32'(gnt), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("abort async gnt", 32'(gnt), 32'd0);
    check("abort async jk", 32'({j, k}), 32'd0);
    check("abort async busy", 32'(busy), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort no done", 32'(done), 32'd0);
    end
    check("abort bank kept", 32'(q), 32'hB1);
    req[0] = 1'b1; op[1:0] = 2'b00; mask[7:0] = 8'h00;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    @(negedge clk);
    check("post-reset done0", 32'(done), 32'b0001);
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post-reset gnt1", 32'(gnt), 32'b0010);
    @(negedge clk);
    check("post-reset q", 32'(q), 32'hFF);
    @(negedge clk);
    check("post-reset done1", 32'(done), 32'b0010);
    check("post-reset err1", 32'(err), 32'd0);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jkff_cmd_arbiter.md
Name: jkff_cmd_arbiter

Overview:
Round-robin controller that shares one bank of WIDTH external jkff instances between NREQ requesters. Each requester asks for a hold, reset, set or toggle on a masked subset of bits. The block drives the bank's j/k vectors for exactly one clock and then reads back q to confirm the result. It sits between requester logic and the jkff bank and is the only driver of the bank's j/k inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, number of jkff bits in the bank

Ports:
clk  input  1  system clock, rising edge; also clocks the jkff bank
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester level request
op  input  2*NREQ  per-requester op, bits [2i+1:2i]: 00 hold, 01 reset, 10 set, 11 toggle
mask  input  WIDTH*NREQ  per-requester bit mask, bits [WIDTH*i+WIDTH-1:WIDTH*i]
gnt  output  NREQ  one-hot grant, high during APPLY and CHECK
done  output  NREQ  one-cycle completion pulse to the granted requester
err  output  1  one-cycle pulse coincident with done when readback mismatches
busy  output  1  high whenever state is not IDLE
j  output  WIDTH  to jkff bank j inputs
k  output  WIDTH  to jkff bank k inputs
q  input  WIDTH  readback from jkff bank q outputs

Behaviour:
- Reset (async, rst_n=0): state IDLE; gnt, done, err, j, k = 0; busy=0; rr pointer=0; latched grant index, op, mask and expected value = 0. The jkff bank itself is not reset by this block.
- All outputs are registered.
- FSM states: IDLE, APPLY, CHECK, DONE. Throughput is one operation per 4 cycles.
- IDLE:
  - If any req is high at edge E0, pick the first high req scanning upward from the rr pointer with wrap.
  - Latch the grant index, op and mask of the winner.
  - Set gnt one-hot and busy=1.
  - Register j/k per bit. Bit with mask=1: hold gives j0/k0, reset gives j0/k1, set gives j1/k0, toggle gives j1/k1. Bit with mask=0: j0/k0.
  - Latch expected = q (hold), q & ~mask (reset), q | mask (set), or q ^ mask (toggle), using q sampled at E0.
  - Go to APPLY.
- APPLY (E0..E1): the bank captures j/k at E1. At E1, clear j and k to 0 and go to CHECK.
- CHECK (E1..E2): at E2, compare q against expected. Assert done[idx]=1 and err=(q != expected), clear gnt, set rr pointer = idx+1 mod NREQ, go to DONE.
- DONE (E2..E3): done and err are high for this cycle only. At E3, clear done and err and go to IDLE. IDLE samples req no earlier than E4.
- Requester protocol:
  - Hold req, op and mask stable from assertion until done is seen.
  - Deassert req at or before the edge after done (E3).
  - Changes to req, op or mask while granted are ignored; there is no abort.
  - req held high after done is treated as a new request.
- mask = 0 with any op: j=k=0 and expected=q. Completes normally with done; err=0 unless q changes externally.
- Simultaneous requests: only the winner is granted. Losers wait; no request is dropped.
- Fairness: after granting index i, index i has lowest priority. Any requester waits at most NREQ-1 operations.
- rst_n asserted mid-operation: immediate return to reset values. No done or err is issued for the aborted op. The bank keeps whatever it captured.

Test Plan:
- Reset, then req[0]=1, op0=01, mask0=FF -> gnt=0001 for 2 cycles; j=00, k=FF for exactly 1 cycle; q=00; done[0] pulses at E2; err=0.
- From q=00: req[1] op=10 mask=0F -> j=0F, k=00 for 1 cycle; q=0F; done[1] pulses; busy high E0..E3.
- From q=0F: req[2] op=11 mask=FF -> j=FF, k=FF for 1 cycle; q=F0; done[2]; err=0. Then req[3] op=00 mask=FF -> j=k=00; q stays F0; done[3].
- All four req high continuously after the last grant went to index 2 -> grant order 3, 0, 1, 2; successive grant edges 4 cycles apart; exactly one done per grant.
- Bench forces q[0] stuck at 0; req[0] op=10 mask=01 -> done[0] and err both pulse high in the same cycle.
- rst_n pulled low during APPLY of a req[1] op -> gnt, j, k, busy go 0 asynchronously; no done[1]. After release with req[1] and req[0] high, the pointer is 0, so req[0] is granted first.
